// File: rtl/cpu_pkg.sv
// Shared fetch-side types and defaults: FSM encoding, FIFO entry layout, boot address.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_GNT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
  } fetch_entry_t;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and free-slot count; data visible the cycle after push (no bypass).
// Push at full is dropped unless a pop happens in the same cycle; flush overrides push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      free_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign free_o  = (AW+1)'(DEPTH) - count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetcher: issues sequential word fetches, tracks in-flight responses, buffers them
// in fetch_fifo, and on redirect flushes the buffer and discards stale responses.
module prefetch_buffer
  import cpu_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = BOOT_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 2);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q;
  logic          instr_req_q;
  logic [31:0]   instr_addr_q;
  logic [31:0]   pc_q;
  logic [31:0]   rsp_addr_q;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          gnt_ev, pending, push, fifo_push, pop, issue_ok;
  logic          fifo_full, fifo_empty;
  logic [FW-1:0] fifo_free;
  logic [31:0]   free_d, target, next_pc;
  fetch_entry_t  wr_entry, rd_entry;

  assign gnt_ev  = instr_req_q && instr_gnt_i;
  assign pending = instr_req_q && !instr_gnt_i;
  assign target  = word_align(branch_addr_i);
  assign next_pc = branch_i ? target : pc_q;

  // Responses in the redirect cycle or still owed to the old path never enter the buffer.
  assign push      = instr_rvalid_i && !branch_i && (discard_q == '0);
  assign fifo_push = push && (!fifo_full || pop);
  assign pop       = fetch_valid_o && fetch_ready_i && !branch_i;

  always_comb begin
    out_d = out_q;
    if (gnt_ev && !instr_rvalid_i)      out_d = out_q + CW'(1);
    else if (!gnt_ev && instr_rvalid_i) out_d = out_q - CW'(1);
  end

  // A request stalled at redirect time will still be granted on its old address, so its
  // response is counted as stale up front.
  always_comb begin
    discard_d = discard_q;
    if (branch_i)                                 discard_d = out_d + CW'(pending);
    else if (instr_rvalid_i && discard_q != '0)   discard_d = discard_q - CW'(1);
  end

  always_comb begin
    if (branch_i) free_d = 32'(FIFO_DEPTH);
    else          free_d = 32'(fifo_free) - 32'(fifo_push) + 32'(pop);
  end

  assign issue_ok = req_i && (32'(out_d) < 32'(MAX_OUTSTANDING)) && (free_d > 32'(out_d));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      instr_req_q  <= 1'b0;
      instr_addr_q <= '0;
      pc_q         <= BOOT_ADDR;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_ok) begin
            state_q      <= REQ;
            instr_req_q  <= 1'b1;
            instr_addr_q <= next_pc;
            pc_q         <= next_pc + 32'd4;
          end else if (branch_i) begin
            pc_q <= target;
          end
        end
        REQ, WAIT_GNT: begin
          if (!instr_gnt_i) begin
            state_q <= WAIT_GNT;
            if (branch_i) pc_q <= target;
          end else if (issue_ok) begin
            state_q      <= REQ;
            instr_addr_q <= next_pc;
            pc_q         <= next_pc + 32'd4;
          end else begin
            state_q     <= IDLE;
            instr_req_q <= 1'b0;
            if (branch_i) pc_q <= target;
          end
        end
        default: begin
          state_q     <= IDLE;
          instr_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Accepted responses are in order and sequential since the last redirect.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q      <= '0;
      discard_q  <= '0;
      rsp_addr_q <= BOOT_ADDR;
    end else begin
      out_q     <= out_d;
      discard_q <= discard_d;
      if (branch_i)  rsp_addr_q <= target;
      else if (push) rsp_addr_q <= rsp_addr_q + 32'd4;
    end
  end

  assign wr_entry.rdata = instr_rdata_i;
  assign wr_entry.addr  = rsp_addr_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (fifo_push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .flush_i (branch_i),
    .data_o  (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  assign fetch_valid_o = !fifo_empty;
  assign fetch_rdata_o = rd_entry.rdata;
  assign fetch_addr_o  = rd_entry.addr;
  assign instr_req_o   = instr_req_q;
  assign instr_addr_o  = instr_addr_q;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer with a one-cycle-latency memory responder (rdata = ~addr).
module tb_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b1;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = 32'h0;

  logic        rsp_hold = 1'b0;
  logic [31:0] rq[$];
  int          n_grant = 0;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  logic [31:0] exp_addr = 32'h0;

  always #5 clk = ~clk;

  prefetch_buffer #(
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .BOOT_ADDR       (32'h0000_0000)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i)
  );

  // Memory: a grant seen before edge k is answered in the cycle ending at edge k+1 (unless held).
  always begin
    @(negedge clk);
    #1;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    if (!rstn_i) begin
      rq.delete();
    end else begin
      if (!rsp_hold && rq.size() != 0) begin
        instr_rdata_i  = ~rq[0];
        instr_rvalid_i = 1'b1;
        void'(rq.pop_front());
      end
      if (instr_req_o && instr_gnt_i) begin
        rq.push_back(instr_addr_o);
        n_grant++;
      end
    end
  end

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
    end
  endtask

  // Checks the head against the expected sequential stream when it is about to be popped.
  task automatic tick();
    if (fetch_valid_o && fetch_ready_i && !branch_i) begin
      chk_word("stream_addr", fetch_addr_o, exp_addr);
      chk_word("stream_data", fetch_rdata_o, ~exp_addr);
      exp_addr = exp_addr + 32'd4;
      n_pop++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   g0;
    int   p0;
    logic found;

    // Asynchronous reset values
    #2 rstn_i = 1'b0;
    #1;
    chk_bit ("rst_req",   instr_req_o,   1'b0);
    chk_word("rst_iaddr", instr_addr_o,  32'h0);
    chk_bit ("rst_valid", fetch_valid_o, 1'b0);
    chk_word("rst_rdata", fetch_rdata_o, 32'h0);
    chk_word("rst_faddr", fetch_addr_o,  32'h0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;

    // Streaming with grant always high
    req_i = 1'b1; instr_gnt_i = 1'b1; fetch_ready_i = 1'b1;
    tick();
    chk_bit ("t1_req",    instr_req_o,   1'b1);
    chk_word("t1_addr0",  instr_addr_o,  32'h0);
    chk_bit ("t1_nv0",    fetch_valid_o, 1'b0);
    tick();
    chk_word("t1_addr4",  instr_addr_o,  32'h4);
    chk_bit ("t1_nv1",    fetch_valid_o, 1'b0);
    tick();
    chk_word("t1_addr8",  instr_addr_o,  32'h8);
    chk_bit ("t1_valid",  fetch_valid_o, 1'b1);
    chk_word("t1_faddr",  fetch_addr_o,  32'h0);
    chk_word("t1_fdata",  fetch_rdata_o, 32'hFFFF_FFFF);

    // Grant withheld for three cycles on 0x8
    instr_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit ("t2_req_hold",  instr_req_o,  1'b1);
      chk_word("t2_addr_hold", instr_addr_o, 32'h8);
    end
    instr_gnt_i = 1'b1; req_i = 1'b0;
    repeat (8) tick();
    chk_bit ("t2_idle", instr_req_o, 1'b0);
    chk_word("t2_pops", n_pop, 3);

    // Consumer stalled: buffer fills to depth and issue stops
    fetch_ready_i = 1'b0; req_i = 1'b1; g0 = n_grant;
    repeat (12) tick();
    chk_word("t3_grants", n_grant - g0, 4);
    chk_bit ("t3_noreq",  instr_req_o,   1'b0);
    chk_bit ("t3_valid",  fetch_valid_o, 1'b1);
    chk_word("t3_head",   fetch_addr_o,  32'hC);
    fetch_ready_i = 1'b1; req_i = 1'b0; p0 = n_pop;
    repeat (10) tick();
    chk_word("t3_drained", n_pop - p0, 4);

    // Redirect with two responses outstanding
    rsp_hold = 1'b1; req_i = 1'b1;
    repeat (4) tick();
    chk_bit ("t4_maxout",   instr_req_o, 1'b0);
    chk_word("t4_inflight", rq.size(),   2);
    branch_i = 1'b1; branch_addr_i = 32'h103;
    tick();
    branch_i = 1'b0; exp_addr = 32'h100;
    chk_bit("t4_flushed", fetch_valid_o, 1'b0);
    rsp_hold = 1'b0; p0 = n_pop; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (instr_req_o) found = 1'b1;
    end
    chk_bit ("t4_req_seen", found,         1'b1);
    chk_word("t4_new_addr", instr_addr_o,  32'h100);
    chk_bit ("t4_dropped",  fetch_valid_o, 1'b0);
    repeat (6) tick();
    chk_bit("t4_popped", (n_pop - p0) > 0, 1'b1);
    req_i = 1'b0;
    repeat (8) tick();

    // Redirect while the request to 0x10 is ungranted
    req_i = 1'b1; instr_gnt_i = 1'b0;
    branch_i = 1'b1; branch_addr_i = 32'h10;
    tick();
    branch_i = 1'b0; exp_addr = 32'h10;
    chk_bit ("t5_req",   instr_req_o,  1'b1);
    chk_word("t5_addr",  instr_addr_o, 32'h10);
    branch_i = 1'b1; branch_addr_i = 32'h200;
    tick();
    branch_i = 1'b0; exp_addr = 32'h200;
    chk_word("t5_hold0", instr_addr_o, 32'h10);
    tick();
    chk_word("t5_hold1", instr_addr_o, 32'h10);
    instr_gnt_i = 1'b1;
    tick();
    chk_word("t5_target", instr_addr_o, 32'h200);
    tick();
    chk_bit("t5_stale_dropped", fetch_valid_o, 1'b0);
    tick();
    chk_bit ("t5_valid", fetch_valid_o, 1'b1);
    chk_word("t5_faddr", fetch_addr_o,  32'h200);
    chk_word("t5_fdata", fetch_rdata_o, 32'hFFFF_FDFF);
    req_i = 1'b0;
    repeat (8) tick();

    // Reset mid-burst with two outstanding
    fetch_ready_i = 1'b0; req_i = 1'b1;
    repeat (3) tick();
    rsp_hold = 1'b1;
    tick();
    chk_word("t6_inflight", rq.size(),     2);
    chk_bit ("t6_noreq",    instr_req_o,   1'b0);
    chk_bit ("t6_valid",    fetch_valid_o, 1'b1);
    #2 rstn_i = 1'b0;
    #1;
    chk_bit ("t6_rst_req",   instr_req_o,   1'b0);
    chk_word("t6_rst_iaddr", instr_addr_o,  32'h0);
    chk_bit ("t6_rst_valid", fetch_valid_o, 1'b0);
    chk_word("t6_rst_rdata", fetch_rdata_o, 32'h0);
    chk_word("t6_rst_faddr", fetch_addr_o,  32'h0);
    tick();
    tick();
    rstn_i = 1'b1; rsp_hold = 1'b0; fetch_ready_i = 1'b1; exp_addr = 32'h0; p0 = n_pop;
    tick();
    chk_bit ("t6_boot_req",  instr_req_o,  1'b1);
    chk_word("t6_boot_addr", instr_addr_o, 32'h0);
    repeat (6) tick();
    chk_bit("t6_popped", (n_pop - p0) > 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
